// File: rtl/pxs_hlines.sv
// Horizontal-line overlay for the iPxs pixel stream: NUM_LINES bands of THICK rows, SPACING apart, from row Y0.
// Optional per-frame scrolling of the band pattern is compiled in when PXS_SCROLL_EN is defined.
`default_nettype none

module pxs_hlines #(
  parameter logic [2:0] COLOR      = 3'b100,
  parameter logic [2:0] BG         = 3'b000,
  parameter int         Y0         = 245,
  parameter int         NUM_LINES  = 4,
  parameter int         SPACING    = 16,
  parameter int         THICK      = 1,
  parameter int         SCROLL_DIV = 2
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [22:0] VGAStr_i,
  output logic [25:0] RGBStr_o,
  output logic [9:0]  offset_o
);

  localparam int PW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int KW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [PW:0] THICK_W = (PW + 1)'(THICK);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   phase_reg, phase_next;
  logic [KW-1:0]   k_reg, k_next;
  logic            resync_reg, resync_next;
  logic            rst_tail_reg;
  logic            prev_vsync_reg;
  logic [9:0]      prev_y_reg;
  logic [22:0]     s1_str_reg;
  logic            s1_en_reg;
  logic [25:0]     out_reg;

  logic [9:0]      y_in;
  logic            vs_in;
  logic            frame_start;
  logic            new_row;
  logic [10:0]     start_row;
  logic [NUM_LINES-1:0] hit;
  logic            hit_any;
  logic [KW-1:0]   hit_k;
  logic [2:0]      rgb;

  assign y_in        = VGAStr_i[12:3];
  assign vs_in       = VGAStr_i[1];
  assign frame_start = prev_vsync_reg & ~vs_in;
  assign new_row     = (y_in != prev_y_reg);

`ifdef PXS_SCROLL_EN
  localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  logic [DW-1:0] div_cnt_reg;
  logic [9:0]    offset_reg;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      offset_reg  <= '0;
    end else if (frame_start) begin
      if (div_cnt_reg == DW'(SCROLL_DIV - 1)) begin
        div_cnt_reg <= '0;
        offset_reg  <= (offset_reg == 10'(SPACING - 1)) ? 10'd0 : offset_reg + 10'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  assign offset_o  = offset_reg;
  assign start_row = 11'(Y0) + {1'b0, offset_reg};
`else
  assign offset_o  = '0;
  assign start_row = 11'(Y0);
`endif

  // Start row of every line; rows past 1023 never equal a 10-bit YCoord.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic [15:0] line_row;
      assign line_row = 16'(start_row) + 16'(gi * SPACING);
      assign hit[gi]  = (line_row == {6'b0, y_in});
    end
  endgenerate

  assign hit_any = |hit;

  always_comb begin
    hit_k = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (hit[i]) hit_k = KW'(i);
    end
  end

  // After a reset the tracker may join at any later line start of the running frame;
  // the frame start seen right after reset (prev_vsync resets high) keeps that allowance.
  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    k_next      = k_reg;
    resync_next = resync_reg;
    if (frame_start) begin
      state_next  = IDLE;
      phase_next  = '0;
      k_next      = '0;
      resync_next = rst_tail_reg ? resync_reg : 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (resync_reg ? hit_any : hit[0]) begin
            state_next = ACTIVE;
            phase_next = '0;
            k_next     = resync_reg ? hit_k : '0;
          end
        end
        ACTIVE: begin
          if (new_row) begin
            if (phase_reg == PW'(SPACING - 1)) begin
              phase_next = '0;
              if (k_reg == KW'(NUM_LINES - 1)) state_next = DONE;
              else k_next = k_reg + 1'b1;
            end else begin
              phase_next = phase_reg + 1'b1;
            end
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Tracker registers hold the state after the stage-1 pixel, so they line up with s1_str_reg.
  assign rgb = (s1_en_reg && s1_str_reg[0] && (state_reg == ACTIVE) && ({1'b0, phase_reg} < THICK_W))
               ? COLOR : BG;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      k_reg          <= '0;
      resync_reg     <= 1'b1;
      rst_tail_reg   <= 1'b1;
      prev_vsync_reg <= 1'b1;
      prev_y_reg     <= '0;
      s1_str_reg     <= '0;
      s1_en_reg      <= 1'b0;
      out_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      k_reg          <= k_next;
      resync_reg     <= resync_next;
      rst_tail_reg   <= 1'b0;
      prev_vsync_reg <= vs_in;
      prev_y_reg     <= y_in;
      s1_str_reg     <= VGAStr_i;
      s1_en_reg      <= enable;
      out_reg        <= {rgb, s1_str_reg};
    end
  end

  assign RGBStr_o = out_reg;

endmodule

`default_nettype wire
